rgu_result_fifo: RTL

- Output buffer directly downstream of the ray generation unit.
- Captures every word the unit emits through its oFifoPush/oFifoData push interface.
- Presents the words to the consumer (ray traversal stage or UART readback) as a first-word-fall-through stream with a valid/ready handshake.
- Provides an almost-full stall to gate the unit's iEnable, plus occupancy and sticky error flags for debug.

---
 rtl/rgu_result_fifo_if.sv | 29 ++
 rtl/rgu_result_fifo.sv | 117 +++++++++++
 2 files changed

// File: rtl/rgu_result_fifo_if.sv
// rtl/rgu_result_fifo_if.sv - push/pop/status bundle between RGU, result FIFO and consumer
// slave modport: FIFO side (takes push data, consumer ready and flag clear; drives status and head word)
// master modport: driver side (RGU push port plus consumer handshake)
interface rgu_result_fifo_if #(
    parameter int GPU_WORD = 32,
    parameter int ADDR_W   = 4
);
    logic                iPush;
    logic [GPU_WORD-1:0] iData;
    logic                oStall;
    logic                oValid;
    logic [GPU_WORD-1:0] oData;
    logic                iReady;
    logic [ADDR_W:0]     oCount;
    logic                oFull;
    logic                oOverflow;
    logic                oUnderflow;
    logic                iClearFlags;

    modport slave (
        input  iPush, iData, iReady, iClearFlags,
        output oStall, oValid, oData, oCount, oFull, oOverflow, oUnderflow
    );

    modport master (
        output iPush, iData, iReady, iClearFlags,
        input  oStall, oValid, oData, oCount, oFull, oOverflow, oUnderflow
    );
endinterface

// File: rtl/rgu_result_fifo.sv
// rtl/rgu_result_fifo.sv - first-word-fall-through result buffer behind the ray generation unit
// Ports: iClock, iReset (async active-low); bus (slave) carries iPush/iData from the RGU,
// oValid/oData/iReady towards the consumer, oStall for RGU iEnable gating, oCount/oFull
// occupancy, sticky oOverflow/oUnderflow with iClearFlags.
module rgu_result_fifo #(
    parameter int GPU_WORD    = 32,
    parameter int ADDR_W      = 4,
    parameter int AFULL_LEVEL = 12
) (
    input  logic               iClock,
    input  logic               iReset,
    rgu_result_fifo_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W+1)'(AFULL_LEVEL);
    localparam logic [ADDR_W:0] ONE_CNT   = (ADDR_W+1)'(1);

    // Storage keeps every queued word, including the current head; the head is
    // additionally mirrored into data_q so oData is a plain register.
    logic [GPU_WORD-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                valid_q, valid_d;
    logic [GPU_WORD-1:0] data_q, data_d;
    logic                stall_q, stall_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;

    logic                pop;
    logic                push;
    logic                full;
    logic [ADDR_W-1:0]   rd_ptr_inc;

    always_comb begin
        full       = (count_q == DEPTH_CNT);
        pop        = valid_q && bus.iReady;
        // A pop frees a slot on the same edge, so a full FIFO still accepts a push.
        push       = bus.iPush && (!full || pop);
        rd_ptr_inc = rd_ptr_q + 1'b1;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_d      = data_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_inc;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Head refresh: after a pop the next word is either already stored
        // behind the head or is the word being pushed on this very edge.
        if (pop) begin
            if (count_q > ONE_CNT)
                data_d = mem_q[rd_ptr_inc];
            else if (push)
                data_d = bus.iData;
        end else if (count_q == '0 && push) begin
            data_d = bus.iData;
        end

        valid_d = (count_d != '0);
        stall_d = (count_d >= AFULL_CNT);

        // Set beats clear when both happen on the same edge.
        if (bus.iClearFlags) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (bus.iPush && !push)      overflow_d  = 1'b1;
        if (bus.iReady && !valid_q)  underflow_d = 1'b1;
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            stall_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            stall_q     <= stall_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is intentionally not reset; pointers and count define what is live.
    always_ff @(posedge iClock) begin
        if (push) mem_q[wr_ptr_q] <= bus.iData;
    end

    assign bus.oValid     = valid_q;
    assign bus.oData      = data_q;
    assign bus.oCount     = count_q;
    assign bus.oFull      = (count_q == DEPTH_CNT);
    assign bus.oStall     = stall_q;
    assign bus.oOverflow  = overflow_q;
    assign bus.oUnderflow = underflow_q;
endmodule
